// File: rtl/a4_q2_shift_add_multiplier_pkg.sv
// Shared types and sizes for the shift-add multiplier
// and its eight-bit adder.
package a4_q2_shift_add_multiplier_pkg;

   localparam int OPERAND_W  = 8;
   localparam int PRODUCT_W  = 16;
   localparam int ITERATIONS = 8;
   localparam int CNT_W      = $clog2(ITERATIONS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/a4_q2_shift_add_multiplier_add.sv
// Eight-bit add/subtract block.
// opcode 0 adds, opcode 1 computes x - y.
import a4_q2_shift_add_multiplier_pkg::*;

module A4_Q1_eight_bit_adder (
   input  logic [OPERAND_W-1:0] i_x,
   input  logic [OPERAND_W-1:0] i_y,
   input  logic                 i_opcode,
   output logic [OPERAND_W-1:0] o_sum,
   output logic                 o_carry,
   output logic                 o_overflow
);

   logic [OPERAND_W-1:0] w_y;

   // Subtract is add of the inverted operand with carry-in 1
   always_comb begin
      w_y = i_opcode ? ~i_y : i_y;
      {o_carry, o_sum} = {1'b0, i_x} + {1'b0, w_y}
                       + {{OPERAND_W{1'b0}}, i_opcode};
      o_overflow = (i_x[OPERAND_W-1] == w_y[OPERAND_W-1])
                && (o_sum[OPERAND_W-1] != i_x[OPERAND_W-1]);
   end

endmodule

// File: rtl/a4_q2_shift_add_multiplier.sv
// Multi-cycle unsigned 8x8 shift-add multiplier
// with start/busy/done handshake.
import a4_q2_shift_add_multiplier_pkg::*;

module a4_q2_shift_add_multiplier #(
   parameter bit SKIP_ZERO = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [OPERAND_W-1:0] multiplicand,
   input  logic [OPERAND_W-1:0] multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [PRODUCT_W-1:0] product
);

   state_t               r_state;
   logic [OPERAND_W-1:0] r_a;
   logic [OPERAND_W-1:0] r_p_hi;
   logic [OPERAND_W-1:0] r_q;
   logic [CNT_W-1:0]     r_cnt;

   logic [OPERAND_W-1:0] w_add_y;
   logic [OPERAND_W-1:0] w_sum;
   logic                 w_carry;
   logic                 w_unused_ovf;
   logic [PRODUCT_W-1:0] w_shifted;
   logic                 w_zero_op;
   logic                 w_last;

   // Partial-product select, shifted result and bypass detect
   always_comb begin
      w_add_y   = r_q[0] ? r_a : '0;
      w_shifted = {w_carry, w_sum, r_q[OPERAND_W-1:1]};
      w_zero_op = (multiplicand == '0) || (multiplier == '0);
      w_last    = (r_cnt == CNT_W'(ITERATIONS - 1));
   end

   A4_Q1_eight_bit_adder u_add (
      .i_x        (r_p_hi),
      .i_y        (w_add_y),
      .i_opcode   (1'b0),
      .o_sum      (w_sum),
      .o_carry    (w_carry),
      .o_overflow (w_unused_ovf)
   );

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_p_hi  <= '0;
         r_q     <= '0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  r_a    <= multiplicand;
                  r_q    <= multiplier;
                  r_p_hi <= '0;
                  r_cnt  <= '0;
                  if (SKIP_ZERO && w_zero_op) begin
                     r_state <= ST_DONE;
                     done    <= 1'b1;
                     product <= '0;
                  end else begin
                     r_state <= ST_RUN;
                     busy    <= 1'b1;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               {r_p_hi, r_q} <= w_shifted;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= ST_DONE;
                  product <= w_shifted;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_a4_q2_shift_add_multiplier.sv
// Self-checking bench: directed handshake cases plus
// randomized operands against an arithmetic reference.
module tb_a4_q2_shift_add_multiplier;

   logic        clk = 1'b0;
   logic        reset;
   logic        s0, s1;
   logic [7:0]  a0, b0, a1, b1;
   logic        busy0, done0, busy1, done1;
   logic [15:0] p0, p1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   a4_q2_shift_add_multiplier #(.SKIP_ZERO(1'b0)) dut0 (
      .clk(clk), .reset(reset), .start(s0),
      .multiplicand(a0), .multiplier(b0),
      .busy(busy0), .done(done0), .product(p0)
   );

   a4_q2_shift_add_multiplier #(.SKIP_ZERO(1'b1)) dut1 (
      .clk(clk), .reset(reset), .start(s1),
      .multiplicand(a1), .multiplier(b1),
      .busy(busy1), .done(done1), .product(p1)
   );

   task automatic chk(input string tag,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s,
                        input logic [7:0] a,
                        input logic [7:0] b);
      s0 = s; a0 = a; b0 = b;
      s1 = s; a1 = a; b1 = b;
   endtask

   task automatic drive_idle();
      drive(1'b0, 8'($urandom), 8'($urandom));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 8'h00, 8'h00);
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Random run on one instance; latency from the
   // handshake rules, product from plain arithmetic
   task automatic rand_run(input int which, input int n);
      logic [15:0] prev = 16'h0000;
      for (int i = 0; i < n; i++) begin
         logic [7:0]  a, b;
         logic [15:0] exp;
         int lat, gap;
         logic bz, dn;
         logic [15:0] pr;
         a = 8'($urandom);
         b = 8'($urandom);
         if ($urandom_range(7) == 0) a = 8'h00;
         if ($urandom_range(7) == 0) b = 8'h00;
         exp = 16'(a) * 16'(b);
         lat = (which == 1 && (a == 0 || b == 0)) ? 1 : 9;
         gap = $urandom_range(3);
         if (which == 0) begin s0 = 1; a0 = a; b0 = b; end
         else begin s1 = 1; a1 = a; b1 = b; end
         for (int k = 1; k <= lat; k++) begin
            tick();
            if (which == 0) begin
               s0 = 0; a0 = 8'($urandom); b0 = 8'($urandom);
               bz = busy0; dn = done0; pr = p0;
            end else begin
               s1 = 0; a1 = 8'($urandom); b1 = 8'($urandom);
               bz = busy1; dn = done1; pr = p1;
            end
            chk("rnd_busy", 32'(bz), 32'(k < lat));
            chk("rnd_done", 32'(dn), 32'(k == lat));
            chk("rnd_prod", 32'(pr), 32'(k == lat ? exp : prev));
         end
         prev = exp;
         for (int g = 0; g < gap; g++) begin
            tick();
            dn = (which == 0) ? done0 : done1;
            pr = (which == 0) ? p0 : p1;
            chk("rnd_gap_done", 32'(dn), 32'd0);
            chk("rnd_gap_prod", 32'(pr), 32'(prev));
         end
      end
      tick();
   endtask

   initial begin
      do_reset();
      chk("rst_busy0", 32'(busy0), 0);
      chk("rst_done0", 32'(done0), 0);
      chk("rst_prod0", 32'(p0), 0);
      chk("rst_busy1", 32'(busy1), 0);
      chk("rst_prod1", 32'(p1), 0);

      // 13 x 11, held through cycle 20
      drive(1'b1, 8'd13, 8'd11);
      for (int c = 1; c <= 20; c++) begin
         tick();
         drive_idle();
         chk("t1_busy0", 32'(busy0), 32'(c >= 1 && c <= 8));
         chk("t1_done0", 32'(done0), 32'(c == 9));
         chk("t1_busy1", 32'(busy1), 32'(c >= 1 && c <= 8));
         chk("t1_done1", 32'(done1), 32'(c == 9));
         if (c >= 9) begin
            chk("t1_prod0", 32'(p0), 13 * 11);
            chk("t1_prod1", 32'(p1), 13 * 11);
         end
      end

      // 255 x 255
      drive(1'b1, 8'd255, 8'd255);
      for (int c = 1; c <= 10; c++) begin
         tick();
         drive_idle();
         chk("t2_done0", 32'(done0), 32'(c == 9));
         chk("t2_prod0", 32'(p0), c >= 9 ? 255 * 255 : 13 * 11);
      end

      // Zero operand: bypass vs full iteration
      drive(1'b1, 8'd0, 8'd200);
      for (int c = 1; c <= 10; c++) begin
         tick();
         drive_idle();
         chk("t3_busy0", 32'(busy0), 32'(c >= 1 && c <= 8));
         chk("t3_done0", 32'(done0), 32'(c == 9));
         chk("t3_prod0", 32'(p0), c >= 9 ? 0 : 255 * 255);
         chk("t3_busy1", 32'(busy1), 0);
         chk("t3_done1", 32'(done1), 32'(c == 1));
         chk("t3_prod1", 32'(p1), 0);
      end

      // Starts while busy ignored; start in done cycle taken
      drive(1'b1, 8'd7, 8'd6);
      for (int c = 1; c <= 18; c++) begin
         tick();
         chk("t4_busy0", 32'(busy0),
             32'((c >= 1 && c <= 8) || (c >= 10 && c <= 17)));
         chk("t4_done0", 32'(done0), 32'(c == 9 || c == 18));
         chk("t4_done1", 32'(done1), 32'(c == 9 || c == 18));
         if (c >= 9) begin
            chk("t4_prod0", 32'(p0), c == 18 ? 81 : 42);
            chk("t4_prod1", 32'(p1), c == 18 ? 81 : 42);
         end
         if (c == 3 || c == 5 || c == 9) drive(1'b1, 8'd9, 8'd9);
         else drive_idle();
      end

      // Reset in the middle of an operation
      drive(1'b1, 8'd100, 8'd3);
      for (int c = 1; c <= 15; c++) begin
         tick();
         reset = (c == 4);
         drive_idle();
         chk("t5_done0", 32'(done0), 0);
         chk("t5_busy0", 32'(busy0), 32'(c <= 4));
         chk("t5_prod0", 32'(p0), c <= 4 ? 81 : 0);
      end
      reset = 1'b0;

      do_reset();
      rand_run(0, 1000);
      rand_run(1, 300);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
